// File: rtl/mf_peak_detect_if.sv
// Sample-in / result-out bundle of the matched-filter peak detector.
// master drives samples and acks; slave (the detector) returns the held result.
interface mf_peak_detect_if #(
  parameter int DW = 38,
  parameter int IW = 6
);
  logic                 frame_start;
  logic                 y_valid;
  logic signed [DW-1:0] y_in;
  logic [DW-2:0]        threshold;
  logic                 result_ack;
  logic                 result_valid;
  logic [DW-2:0]        peak_mag;
  logic [IW-1:0]        peak_idx;
  logic [IW:0]          hit_cnt;
  logic                 detect;
  logic                 overrun;

  modport master (
    output frame_start, y_valid, y_in, threshold, result_ack,
    input  result_valid, peak_mag, peak_idx, hit_cnt, detect, overrun
  );

  modport slave (
    input  frame_start, y_valid, y_in, threshold, result_ack,
    output result_valid, peak_mag, peak_idx, hit_cnt, detect, overrun
  );
endinterface

// File: rtl/mf_peak_detect.sv
// Per-frame peak magnitude / index / threshold-hit tracker; the result is held until acked.
// result_valid rises on the edge that captures the last sample; samples offered in REPORT are dropped and flagged as overrun.
module mf_peak_detect #(
  parameter int FRAME_LEN = 60,
  parameter int DW        = 38,
  parameter int IW        = 6
) (
  input logic              clk,
  input logic              rst,
  mf_peak_detect_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  state_t        state, state_nxt;
  logic [IW-1:0] cnt;
  logic [DW-2:0] thr_lat;
  logic          rv_q, det_q, ovr_q;
  logic [DW-2:0] peak_q;
  logic [IW-1:0] idx_q;
  logic [IW:0]   hit_q;

  logic [DW-1:0] abs_full;
  logic [DW-2:0] mag, thr_eff, base_peak, new_peak;
  logic [IW-1:0] k, base_idx, new_idx;
  logic [IW:0]   base_hit, new_hit;
  logic          start, take, upd, last;

  always_comb begin
    abs_full = bus.y_in[DW-1] ? (~bus.y_in + DW'(1)) : bus.y_in;
    // -2^(DW-1) has no positive counterpart; clamp it to the largest magnitude
    mag       = (bus.y_in == MOST_NEG) ? '1 : abs_full[DW-2:0];
    start     = bus.frame_start && (state != REPORT || bus.result_ack);
    take      = bus.y_valid && (start || state == ACCUM);
    k         = start ? '0 : cnt;
    thr_eff   = start ? bus.threshold : thr_lat;
    base_peak = start ? '0 : peak_q;
    base_idx  = start ? '0 : idx_q;
    base_hit  = start ? '0 : hit_q;
    upd       = (mag > base_peak) || (k == '0);
    new_peak  = upd ? mag : base_peak;
    new_idx   = upd ? k : base_idx;
    new_hit   = base_hit + (IW+1)'(mag >= thr_eff);
    last      = take && (k == IW'(FRAME_LEN-1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = last ? REPORT : ACCUM;
      ACCUM:   if (last)  state_nxt = REPORT;
      REPORT:  if (bus.result_ack) state_nxt = start ? (last ? REPORT : ACCUM) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      thr_lat <= '0;
      rv_q    <= 1'b0;
      det_q   <= 1'b0;
      ovr_q   <= 1'b0;
      peak_q  <= '0;
      idx_q   <= '0;
      hit_q   <= '0;
    end else begin
      if (start) begin
        thr_lat <= bus.threshold;
        cnt     <= '0;
        peak_q  <= '0;
        idx_q   <= '0;
        hit_q   <= '0;
      end
      if (take) begin
        cnt    <= k + IW'(1);
        peak_q <= new_peak;
        idx_q  <= new_idx;
        hit_q  <= new_hit;
      end
      if (state == REPORT && bus.result_ack) rv_q <= 1'b0;
      if (last) begin
        rv_q  <= 1'b1;
        det_q <= (new_peak >= thr_eff);
      end
      if (state == REPORT && !bus.result_ack && bus.y_valid) ovr_q <= 1'b1;
    end
  end

  assign bus.result_valid = rv_q;
  assign bus.peak_mag     = peak_q;
  assign bus.peak_idx     = idx_q;
  assign bus.hit_cnt      = hit_q;
  assign bus.detect       = det_q;
  assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_mf_peak_detect.sv
// Self-checking bench: directed frames with literal expectations plus randomized frames,
// all compared every cycle against a frame-level model built on a queue of sample magnitudes.
module tb_mf_peak_detect;
  localparam int    FL   = 60;
  localparam int    DW   = 38;
  localparam int    IW   = 6;
  localparam longint MAXM = (longint'(1) << 37) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  mf_peak_detect_if #(.DW(DW), .IW(IW)) bus ();

  mf_peak_detect #(.FRAME_LEN(FL), .DW(DW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic longint magf(input logic signed [DW-1:0] v);
    longint x;
    x = v;
    if (x < 0) x = -x;
    if (x > MAXM) x = MAXM;
    return x;
  endfunction

  // Reference model: 0 idle, 1 collecting, 2 holding a result
  int     mode = 0;
  longint q[$];
  longint thr_l = 0;
  bit     m_rv = 0, m_ovr = 0, e_det = 0;
  longint e_peak = 0, e_idx = 0, e_hit = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode = 0; q.delete(); m_rv = 0; m_ovr = 0;
      e_peak = 0; e_idx = 0; e_hit = 0; e_det = 0;
    end else begin
      bit st;
      st = bus.frame_start && (mode != 2 || bus.result_ack);
      if (mode == 2) begin
        if (bus.result_ack) begin
          m_rv = 0;
          mode = 0;
        end else if (bus.y_valid) m_ovr = 1;
      end
      if (st) begin
        q.delete();
        thr_l = bus.threshold;
        mode = 1;
      end
      if (mode == 1 && bus.y_valid) begin
        q.push_back(magf(bus.y_in));
        if (q.size() == FL) begin
          e_peak = q[0]; e_idx = 0; e_hit = 0;
          foreach (q[i]) begin
            if (q[i] > e_peak) begin
              e_peak = q[i];
              e_idx = i;
            end
            if (q[i] >= thr_l) e_hit++;
          end
          e_det = (e_peak >= thr_l);
          m_rv = 1;
          mode = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("result_valid", bus.result_valid, m_rv);
      chk("overrun", bus.overrun, m_ovr);
      if (m_rv) begin
        chk("peak_mag", bus.peak_mag, e_peak);
        chk("peak_idx", bus.peak_idx, e_idx);
        chk("hit_cnt", bus.hit_cnt, e_hit);
        chk("detect", bus.detect, e_det);
      end
    end
  end

  logic signed [DW-1:0] fvals [FL];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n samples of fvals with a frame_start on the first; leaves time at #1 after the last capture edge.
  task automatic send_frame(input logic [DW-2:0] thr, input int gap_every, input int gap_len,
                            input bit with_ack, input int n);
    bus.frame_start = 1'b1;
    bus.result_ack  = with_ack;
    bus.threshold   = thr;
    bus.y_valid     = 1'b1;
    bus.y_in        = fvals[0];
    step();
    bus.frame_start = 1'b0;
    bus.result_ack  = 1'b0;
    for (int k = 1; k < n; k++) begin
      if (gap_every > 0 && (k % gap_every) == 0) begin
        bus.y_valid = 1'b0;
        repeat (gap_len) step();
      end
      bus.y_valid = 1'b1;
      bus.y_in    = fvals[k];
      step();
    end
    bus.y_valid = 1'b0;
  endtask

  task automatic ack();
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
  endtask

  task automatic fill_const(input logic signed [DW-1:0] v);
    for (int i = 0; i < FL; i++) fvals[i] = v;
  endtask

  task automatic fill_rand();
    int m;
    m = $urandom_range(2, 0);
    for (int i = 0; i < FL; i++) begin
      if (m == 0) fvals[i] = DW'($signed($urandom_range(100, 0)) - 50);
      else        fvals[i] = {$urandom, $urandom};
      if ($urandom_range(40, 0) == 0) fvals[i] = {1'b1, {(DW-1){1'b0}}};
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rv"},   bus.result_valid, 0);
    chk({tag, "_peak"}, bus.peak_mag, 0);
    chk({tag, "_idx"},  bus.peak_idx, 0);
    chk({tag, "_hit"},  bus.hit_cnt, 0);
    chk({tag, "_det"},  bus.detect, 0);
    chk({tag, "_ovr"},  bus.overrun, 0);
  endtask

  initial begin
    logic [DW-2:0] held;
    bus.frame_start = 0; bus.y_valid = 0; bus.y_in = '0; bus.threshold = '0; bus.result_ack = 0;
    #1;
    check_zero("reset");
    repeat (3) step();
    rst = 1'b1;
    cmp_en = 1'b1;

    // Reset mid-frame
    for (int i = 0; i < FL; i++) fvals[i] = DW'(i * 37 + 5);
    send_frame(37'd100, 0, 0, 1'b0, 20);
    #3 rst = 1'b0;
    #1 check_zero("midrst");
    step();
    rst = 1'b1;
    step();

    // Ramp frame
    for (int i = 0; i < FL; i++) fvals[i] = DW'(i * 1000);
    send_frame(37'd30000, 0, 0, 1'b0, FL);
    chk("ramp_rv", bus.result_valid, 1);
    chk("ramp_peak", bus.peak_mag, 59000);
    chk("ramp_idx", bus.peak_idx, 59);
    chk("ramp_hit", bus.hit_cnt, 30);
    chk("ramp_det", bus.detect, 1);
    repeat (10) step();
    chk("hold_rv", bus.result_valid, 1);
    chk("hold_peak", bus.peak_mag, 59000);
    bus.y_valid = 1'b1; bus.y_in = DW'(123456);
    step();
    bus.y_valid = 1'b0;
    chk("ovr_set", bus.overrun, 1);
    chk("ovr_peak", bus.peak_mag, 59000);

    // Negative peak frame entered via ack+frame_start+y_valid
    fill_const('0);
    fvals[0]  = DW'(-10);
    fvals[17] = DW'(-5000);
    bus.result_ack = 1'b1;
    bus.frame_start = 1'b1; bus.threshold = 37'd1; bus.y_valid = 1'b1; bus.y_in = fvals[0];
    step();
    chk("chain_rv_drop", bus.result_valid, 0);
    chk("chain_idx0_peak", bus.peak_mag, 10);
    send_frame(37'd1, 0, 0, 1'b0, 0);
    bus.frame_start = 1'b0; bus.result_ack = 1'b0;
    for (int k = 1; k < FL; k++) begin
      bus.y_valid = 1'b1; bus.y_in = fvals[k];
      step();
    end
    bus.y_valid = 1'b0;
    chk("neg_peak", bus.peak_mag, 5000);
    chk("neg_idx", bus.peak_idx, 17);
    ack();

    // Saturating most-negative input
    fill_const('0);
    fvals[3] = {1'b1, {(DW-1){1'b0}}};
    send_frame(37'd1000, 0, 0, 1'b0, FL);
    chk("sat_peak", bus.peak_mag, MAXM);
    chk("sat_idx", bus.peak_idx, 3);
    ack();

    // Tie with stalls
    fill_const('0);
    fvals[10] = DW'(700);
    fvals[40] = DW'(700);
    send_frame(37'd800, 8, 3, 1'b0, FL - 1);
    chk("tie_not_yet", bus.result_valid, 0);
    bus.y_valid = 1'b1; bus.y_in = fvals[FL-1];
    step();
    bus.y_valid = 1'b0;
    chk("tie_rv", bus.result_valid, 1);
    chk("tie_idx", bus.peak_idx, 10);
    chk("tie_hit", bus.hit_cnt, 0);
    chk("tie_det", bus.detect, 0);
    ack();

    // Restart mid-frame
    fill_rand();
    send_frame(37'd5, 0, 0, 1'b0, 30);
    chk("abort_rv", bus.result_valid, 0);
    fill_rand();
    send_frame(37'd50, 0, 0, 1'b0, FL);
    chk("restart_rv", bus.result_valid, 1);
    held = bus.peak_mag;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    chk("fs_no_ack_ignored", bus.peak_mag, held);
    ack();

    // Randomized frames
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(3, 0)) begin
        bus.y_valid = $urandom_range(1, 0);
        bus.result_ack = $urandom_range(1, 0);
        bus.y_in = {$urandom, $urandom};
        step();
      end
      bus.y_valid = 1'b0; bus.result_ack = 1'b0;
      if ($urandom_range(3, 0) == 0) begin
        fill_rand();
        send_frame(37'($urandom), $urandom_range(6, 0), $urandom_range(2, 1), 1'b0,
                   $urandom_range(FL - 1, 1));
      end
      fill_rand();
      send_frame((r % 2) ? {$urandom, $urandom} : 37'($urandom_range(60, 0)),
                 $urandom_range(9, 0), $urandom_range(3, 1), 1'b0, FL);
      repeat ($urandom_range(4, 0)) begin
        bus.y_valid = $urandom_range(1, 0);
        step();
      end
      bus.y_valid = 1'b0;
      ack();
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
